// File: rtl/fpa_arbiter_if.sv
// Request, response and adder-side signals of fpa_arbiter.
// The arbiter takes the slave modport; requesters, consumer and adder model take the master modport.
interface fpa_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;

  logic              resp_valid;
  logic [2:0]        resp_id;
  logic [W-1:0]      resp_data;
  logic              resp_err;
  logic              resp_ready;

  logic              fpa_add;
  logic [W-1:0]      fpa_number1;
  logic [W-1:0]      fpa_number2;
  logic [W-1:0]      fpa_result;
  logic              fpa_ready;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, fpa_result, fpa_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_err,
           fpa_add, fpa_number1, fpa_number2
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready, fpa_result, fpa_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err,
           fpa_add, fpa_number1, fpa_number2
  );
endinterface

// File: rtl/fpa_arbiter.sv
// Round-robin arbiter sharing one half-precision floating_point_adder among NREQ requesters.
// Defining FPA_ARB_TIMEOUT_EN adds a watchdog that ends a stuck add with resp_err after TIMEOUT cycles.
module fpa_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         CLOCK_50,
  input  logic         rst_n,
  fpa_arbiter_if.slave bus
);
  localparam int unsigned IDW = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_BLANK = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT == 0) begin : g_param_check
    $error("fpa_arbiter: NREQ must be 2..8 and TIMEOUT must be nonzero");
  end

  state_e         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   data_q, data_d;
  logic           add_q, add_d;
  logic           valid_q, valid_d;

`ifdef FPA_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  logic [NREQ-1:0] above_c;
  logic [NREQ-1:0] masked_c;
  logic [NREQ-1:0] pick_c;
  logic [NREQ-1:0] grant_oh_c;
  logic [NREQ-1:0] ready_c;
  logic [IDW-1:0]  grant_id_c;
  logic            grant_any_c;
  logic [W-1:0]    sel_a_c;
  logic [W-1:0]    sel_b_c;

  // Round-robin pick: lowest requester above last_grant, else wrap to the lowest overall.
  always_comb begin
    above_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      above_c[i] = (IDW'(i) > last_q);
    end
    masked_c    = bus.req_valid & above_c;
    pick_c      = (|masked_c) ? masked_c : bus.req_valid;
    grant_any_c = |bus.req_valid;

    grant_id_c = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (pick_c[i]) grant_id_c = IDW'(i);
    end

    grant_oh_c = '0;
    sel_a_c    = '0;
    sel_b_c    = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_id_c == IDW'(i)) begin
        grant_oh_c[i] = 1'b1;
        sel_a_c       = bus.req_a[i*W +: W];
        sel_b_c       = bus.req_b[i*W +: W];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    data_d  = data_q;
    add_d   = 1'b0;
    valid_d = valid_q;
    ready_c = '0;
`ifdef FPA_ARB_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (grant_any_c) begin
          // Acceptance pulse is combinational so it coincides with req_valid in IDLE only.
          ready_c = grant_oh_c & {NREQ{rst_n}};
          last_d  = grant_id_c;
          id_d    = grant_id_c;
          opa_d   = sel_a_c;
          opb_d   = sel_b_c;
          add_d   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef FPA_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = S_BLANK;
      end
      // Any fpa_ready seen here may be left over from the previous add.
      S_BLANK: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.fpa_ready) begin
          data_d  = bus.fpa_result;
          valid_d = 1'b1;
          state_d = S_RESP;
`ifdef FPA_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d    = wd_q + WD_W'(1);
`endif
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
`ifdef FPA_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      data_q  <= '0;
      add_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef FPA_ARB_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      data_q  <= data_d;
      add_q   <= add_d;
      valid_q <= valid_d;
`ifdef FPA_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.req_ready   = ready_c;
  assign bus.fpa_add     = add_q;
  assign bus.fpa_number1 = opa_q;
  assign bus.fpa_number2 = opb_q;
  assign bus.resp_valid  = valid_q;
  assign bus.resp_id     = id_q;
  assign bus.resp_data   = data_q;
`ifdef FPA_ARB_TIMEOUT_EN
  assign bus.resp_err    = err_q;
`else
  assign bus.resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fpa_arbiter.sv
// Directed self-checking bench for fpa_arbiter with a behavioural adder returning hand-computed sums.
// Build with FPA_ARB_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT=8).
`timescale 1ns/1ps
module tb_fpa_arbiter;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned W       = 16;
  localparam int unsigned TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  fpa_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  fpa_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  // Adder model: returns sum_val dly cycles after an add; shows stale_val in between.
  int unsigned  dly       = 3;
  int unsigned  cnt       = 0;
  int unsigned  add_cnt   = 0;
  logic         stale_mode = 1'b0;
  logic [W-1:0] sum_val   = '0;
  logic [W-1:0] stale_val = '0;
  logic         rdy_q     = 1'b0;
  logic [W-1:0] res_q     = '0;

  always @(posedge clk) begin
    if (bus.fpa_add) begin
      cnt     <= dly;
      rdy_q   <= 1'b0;
      res_q   <= stale_val;
      add_cnt <= add_cnt + 1;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        rdy_q <= 1'b1;
        res_q <= sum_val;
      end
    end
  end

  assign bus.fpa_ready  = stale_mode | rdy_q;
  assign bus.fpa_result = res_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  task automatic wait_resp(input int max_cyc, output int cyc);
    cyc = 0;
    while (bus.resp_valid !== 1'b1 && cyc < max_cyc) begin
      @(negedge clk); #1;
      cyc++;
    end
    check_eq("resp_seen", 32'(bus.resp_valid === 1'b1), 32'd1);
  endtask

  task automatic wait_grant(output int id);
    int c;
    c  = 0;
    id = -1;
    while (bus.req_ready == '0 && c < 40) begin
      @(negedge clk); #1;
      c++;
    end
    check_eq("grant_seen", 32'(bus.req_ready != '0), 32'd1);
    check_eq("grant_onehot", 32'($countones(bus.req_ready)), 32'd1);
    for (int i = 0; i < int'(NREQ); i++) begin
      if (bus.req_ready[i]) id = i;
    end
  endtask

  initial begin
    #100us;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int c, lat, stable, grants, seen, id, add0;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;

    // Reset state, with requests already pending.
    @(negedge clk);
    bus.req_valid = '1;
    #1;
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_ctl", 32'({bus.fpa_add, bus.resp_valid, bus.resp_err, bus.resp_id}), 32'd0);
    check_eq("rst_data", 32'(bus.resp_data), 32'd0);
    check_eq("rst_ops", 32'({bus.fpa_number1, bus.fpa_number2}), 32'd0);
    bus.req_valid = '0;

    // Single request 17+18 granted on the first edge after reset release.
    @(negedge clk);
    rst_n     = 1'b1;
    sum_val   = 16'h5060;
    stale_val = 16'hDEAD;
    dly       = 3;
    set_ops(0, 16'h4C40, 16'h4C80);
    bus.req_valid = 4'b0001;
    add0 = int'(add_cnt);
    #1;
    check_eq("t1_grant", 32'(bus.req_ready), 32'b0001);
    @(negedge clk); #1;
    bus.req_valid = 4'b0010;
    set_ops(1, 16'h3C00, 16'h3C00);
    check_eq("t1_issue_add", 32'(bus.fpa_add), 32'd1);
    check_eq("t1_issue_ops", 32'({bus.fpa_number1, bus.fpa_number2}), 32'h4C404C80);
    check_eq("t1_busy_ready", 32'(bus.req_ready), 32'd0);
    wait_resp(20, c);
    check_eq("t1_data", 32'(bus.resp_data), 32'h5060);
    check_eq("t1_id", 32'(bus.resp_id), 32'd0);
    check_eq("t1_err", 32'(bus.resp_err), 32'd0);
    check_eq("t1_add_pulses", 32'(int'(add_cnt) - add0), 32'd1);
    check_eq("t1_resp_add", 32'(bus.fpa_add), 32'd0);
    check_eq("t1_resp_ops", 32'({bus.fpa_number1, bus.fpa_number2}), 32'h4C404C80);

    // Backpressure for 10 cycles with requester 1 pending.
    stable = 0;
    grants = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (bus.resp_valid === 1'b1 && bus.resp_data === 16'h5060 && bus.resp_id === 3'd0) stable++;
      if (bus.req_ready != '0) grants++;
    end
    check_eq("bp_stable", 32'(stable), 32'd10);
    check_eq("bp_no_grant", 32'(grants), 32'd0);
    sum_val = 16'h4000;
    bus.resp_ready = 1'b1;
    @(negedge clk); #1;
    check_eq("bp_released", 32'(bus.resp_valid), 32'd0);
    check_eq("rr_next", 32'(bus.req_ready), 32'b0010);
    @(negedge clk); #1;
    bus.req_valid = '0;
    wait_resp(20, c);
    check_eq("t2_id", 32'(bus.resp_id), 32'd1);
    check_eq("t2_data", 32'(bus.resp_data), 32'h4000);

    // Reset while waiting on the adder.
    @(negedge clk); @(negedge clk);
    dly     = 20;
    sum_val = 16'h4400;
    set_ops(2, 16'h4000, 16'h4000);
    bus.req_valid = 4'b0100;
    #1;
    check_eq("t3_grant", 32'(bus.req_ready), 32'b0100);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rstw_ctl", 32'({bus.fpa_add, bus.resp_valid, bus.resp_err, bus.resp_id, bus.req_ready}), 32'd0);
    check_eq("rstw_ops", 32'({bus.fpa_number1, bus.fpa_number2}), 32'd0);
    check_eq("rstw_data", 32'(bus.resp_data), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      if (bus.resp_valid !== 1'b0) seen++;
    end
    check_eq("rstw_no_resp", 32'(seen), 32'd0);

    // Fairness with all four requesting continuously.
    dly       = 1;
    sum_val   = 16'h1234;
    for (int i = 0; i < int'(NREQ); i++) set_ops(i, 16'h3C00, 16'h3C00);
    bus.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(id);
      check_eq($sformatf("rr_order%0d", k), 32'(id), 32'(exp_order[k]));
      @(negedge clk); #1;
    end
    bus.req_valid = '0;
    wait_resp(20, c);
    check_eq("rr_last_id", 32'(bus.resp_id), 32'd0);
    @(negedge clk); @(negedge clk); #1;

    // fpa_ready stuck high: the result must be taken in WAIT, not in BLANK.
    stale_mode = 1'b1;
    stale_val  = 16'h1111;
    sum_val    = 16'h5040;
    set_ops(3, 16'h4C40, 16'h4C40);
    bus.req_valid = 4'b1000;
    #1;
    check_eq("t5_grant", 32'(bus.req_ready), 32'b1000);
    @(negedge clk); #1;
    bus.req_valid = '0;
    lat = 1;
    wait_resp(20, c);
    lat += c;
    check_eq("t5_latency", 32'(lat), 32'd4);
    check_eq("t5_data", 32'(bus.resp_data), 32'h5040);
    check_eq("t5_id", 32'(bus.resp_id), 32'd3);
    check_eq("t5_ops", 32'({bus.fpa_number1, bus.fpa_number2}), 32'h4C404C40);
    stale_mode = 1'b0;
    @(negedge clk); @(negedge clk); #1;

`ifdef FPA_ARB_TIMEOUT_EN
    // Adder never answers: watchdog ends the transaction after 8 WAIT cycles.
    dly = 0;
    set_ops(1, 16'h4C40, 16'h4C40);
    bus.req_valid = 4'b0010;
    #1;
    check_eq("t6_grant", 32'(bus.req_ready), 32'b0010);
    @(negedge clk); #1;
    bus.req_valid = '0;
    lat = 1;
    wait_resp(40, c);
    lat += c;
    check_eq("t6_latency", 32'(lat), 32'd11);
    check_eq("t6_err", 32'(bus.resp_err), 32'd1);
    check_eq("t6_data", 32'(bus.resp_data), 32'd0);
    check_eq("t6_id", 32'(bus.resp_id), 32'd1);
    @(negedge clk); #1;
    check_eq("t6_err_clear", 32'({bus.resp_valid, bus.resp_err}), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
